// File: rtl/elementwise_mult_if.sv
// Purpose : operand-in / product-out handshake bundle for elementwise_mult.
// Latency : n/a (wires only).
// Backpressure: vld_in/rdy_out on the operand side, vld_out/rdy_in on the product side.
// Ports   : vld_in, a_in, b_in (upstream -> block); rdy_out (block -> upstream);
//           vld_out, list_out (block -> reducer); rdy_in (reducer -> block).
//           The slave modport is the block's view; master is the driver's view.

`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 64
`endif
`ifndef Q_WIDTH
`define Q_WIDTH(I, F) ((I) + (F) + 1)
`endif
`ifndef Q_I
`define Q_I 3
`endif
`ifndef Q_F
`define Q_F 4
`endif
`ifndef K_I
`define K_I 3
`endif
`ifndef K_F
`define K_F 4
`endif
`ifndef PRODUCT_I
`define PRODUCT_I 7
`endif
`ifndef PRODUCT_F
`define PRODUCT_F 8
`endif

interface elementwise_mult_if #(
  parameter int LEN = `MAX_EMBEDDING_DIM,
  parameter int W_A = `Q_WIDTH(`Q_I, `Q_F),
  parameter int W_B = `Q_WIDTH(`K_I, `K_F),
  parameter int W_P = `Q_WIDTH(`PRODUCT_I, `PRODUCT_F)
);
  logic                  vld_in;
  logic                  rdy_out;
  logic signed [W_A-1:0] a_in     [0:LEN-1];
  logic signed [W_B-1:0] b_in     [0:LEN-1];
  logic                  vld_out;
  logic                  rdy_in;
  logic signed [W_P-1:0] list_out [0:LEN-1];

  modport slave (
    input  vld_in, a_in, b_in, rdy_in,
    output rdy_out, vld_out, list_out
  );

  modport master (
    output vld_in, a_in, b_in, rdy_in,
    input  rdy_out, vld_out, list_out
  );
endinterface

// File: rtl/elementwise_mult.sv
// Purpose : folded Q x K elementwise multiplier (LANES multipliers over PASSES cycles),
//           each product arithmetically shifted right by SHIFT and saturated to W_P bits.
// Latency : accept at edge T -> vld_out high after edge T+PASSES; one vector per PASSES+1 cycles streaming.
// Backpressure: rdy_out low while computing; in DONE rdy_out follows rdy_in so a new vector
//           is accepted in the same cycle the current result transfers; results held while rdy_in=0.
// Ports   : clock (rising edge), reset (async, active-low), bus (elementwise_mult_if.slave).

`ifndef MAX_EMBEDDING_DIM
`define MAX_EMBEDDING_DIM 64
`endif
`ifndef Q_WIDTH
`define Q_WIDTH(I, F) ((I) + (F) + 1)
`endif
`ifndef Q_I
`define Q_I 3
`endif
`ifndef Q_F
`define Q_F 4
`endif
`ifndef K_I
`define K_I 3
`endif
`ifndef K_F
`define K_F 4
`endif
`ifndef PRODUCT_I
`define PRODUCT_I 7
`endif
`ifndef PRODUCT_F
`define PRODUCT_F 8
`endif

module elementwise_mult #(
  parameter int LEN    = `MAX_EMBEDDING_DIM,
  parameter int W_A    = `Q_WIDTH(`Q_I, `Q_F),
  parameter int W_B    = `Q_WIDTH(`K_I, `K_F),
  parameter int W_P    = `Q_WIDTH(`PRODUCT_I, `PRODUCT_F),
  parameter int SHIFT  = (`Q_F + `K_F) - `PRODUCT_F,
  parameter int LANES  = 8,
  parameter int PASSES = LEN / LANES
) (
  input logic               clock,
  input logic               reset,
  elementwise_mult_if.slave bus
);

  localparam int CW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam int IW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int WF = W_A + W_B;                       // full product width
  localparam int WX = ((WF > W_P) ? WF : W_P) + 1;     // room to compare against the clamp limits
  localparam logic signed [W_P-1:0] P_MAX = {1'b0, {(W_P-1){1'b1}}};
  localparam logic signed [W_P-1:0] P_MIN = {1'b1, {(W_P-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  vld_out_q;
  logic                  rdy_out_c;
  logic                  accept;
  logic signed [W_A-1:0] a_q      [0:LEN-1];
  logic signed [W_B-1:0] b_q      [0:LEN-1];
  logic signed [W_P-1:0] list_q   [0:LEN-1];
  logic signed [W_P-1:0] lane_res [0:LANES-1];

  // Element index handled by lane k during pass c.
  function automatic logic [IW-1:0] lane_idx(input logic [CW-1:0] c, input int k);
    return IW'(int'(c) * LANES + k);
  endfunction

  // Clamp a shifted full-width product into the signed W_P range.
  function automatic logic signed [W_P-1:0] sat_p(input logic signed [WF-1:0] v);
    logic signed [WX-1:0] x;
    x = WX'(v);
    if (x > WX'(P_MAX))      return P_MAX;
    else if (x < WX'(P_MIN)) return P_MIN;
    else                     return x[W_P-1:0];
  endfunction

  // One physical multiplier per lane; its operands are muxed by the pass counter.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [W_A-1:0] a_sel;
    logic signed [W_B-1:0] b_sel;
    logic signed [WF-1:0]  prod;

    assign a_sel       = a_q[lane_idx(cnt, k)];
    assign b_sel       = b_q[lane_idx(cnt, k)];
    assign prod        = WF'(a_sel) * WF'(b_sel);
    assign lane_res[k] = sat_p(prod >>> SHIFT);
  end

  // rdy_in -> rdy_out is the only combinational control path, active only in DONE.
  assign rdy_out_c = (state == IDLE) | ((state == DONE) & bus.rdy_in);
  assign accept    = bus.vld_in & rdy_out_c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      vld_out_q <= 1'b0;
      for (int i = 0; i < LEN; i++) begin
        a_q[i]    <= '0;
        b_q[i]    <= '0;
        list_q[i] <= '0;
      end
    end else begin
      if (accept) begin
        for (int i = 0; i < LEN; i++) begin
          a_q[i] <= bus.a_in[i];
          b_q[i] <= bus.b_in[i];
        end
      end

      case (state)
        IDLE: begin
          if (bus.vld_in) begin
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          // Lanes outside the current group keep whatever they held before.
          for (int k = 0; k < LANES; k++) begin
            list_q[lane_idx(cnt, k)] <= lane_res[k];
          end
          if (cnt == CW'(PASSES - 1)) begin
            cnt       <= '0;
            vld_out_q <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (bus.rdy_in) begin
            vld_out_q <= 1'b0;
            cnt       <= '0;
            state     <= bus.vld_in ? BUSY : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rdy_out  = rdy_out_c;
  assign bus.vld_out  = vld_out_q;
  assign bus.list_out = list_q;

endmodule

// File: tb/tb_elementwise_mult.sv
// Purpose : self-checking bench for elementwise_mult over three configurations:
//           d0 LEN=4 LANES=2 W_P=16 SHIFT=0, d1 LEN=4 LANES=2 W_P=12 SHIFT=2, d2 LEN=4 LANES=4 W_P=16 SHIFT=0.
// Stimulus: fixed vector table, back-pressure / streaming / async reset sequences, random vectors vs reference model.

module tb_elementwise_mult;

  typedef int vec_t [4];
  typedef struct {
    int   d;
    vec_t a;
    vec_t b;
    vec_t e;
  } vec_rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [2:0]          vld_d;
  logic [2:0]          rdy_d;
  logic signed [7:0]   a_drv [0:3];
  logic signed [7:0]   b_drv [0:3];
  logic [2:0]          vo;
  logic [2:0]          ro;
  int                  got [3][4];

  int n_chk  = 0;
  int n_pass = 0;

  int cfg_sh [3] = '{0, 2, 0};
  int cfg_wp [3] = '{16, 12, 16};
  int cfg_ps [3] = '{2, 2, 1};

  elementwise_mult_if #(.LEN(4), .W_A(8), .W_B(8), .W_P(16)) if0 ();
  elementwise_mult_if #(.LEN(4), .W_A(8), .W_B(8), .W_P(12)) if1 ();
  elementwise_mult_if #(.LEN(4), .W_A(8), .W_B(8), .W_P(16)) if2 ();

  elementwise_mult #(.LEN(4), .W_A(8), .W_B(8), .W_P(16), .SHIFT(0), .LANES(2)) dut0 (
    .clock(clk), .reset(rst_n), .bus(if0.slave));
  elementwise_mult #(.LEN(4), .W_A(8), .W_B(8), .W_P(12), .SHIFT(2), .LANES(2)) dut1 (
    .clock(clk), .reset(rst_n), .bus(if1.slave));
  elementwise_mult #(.LEN(4), .W_A(8), .W_B(8), .W_P(16), .SHIFT(0), .LANES(4)) dut2 (
    .clock(clk), .reset(rst_n), .bus(if2.slave));

  assign if0.vld_in = vld_d[0];
  assign if1.vld_in = vld_d[1];
  assign if2.vld_in = vld_d[2];
  assign if0.rdy_in = rdy_d[0];
  assign if1.rdy_in = rdy_d[1];
  assign if2.rdy_in = rdy_d[2];
  assign if0.a_in   = a_drv;
  assign if1.a_in   = a_drv;
  assign if2.a_in   = a_drv;
  assign if0.b_in   = b_drv;
  assign if1.b_in   = b_drv;
  assign if2.b_in   = b_drv;

  always_comb begin
    vo = {if2.vld_out, if1.vld_out, if0.vld_out};
    ro = {if2.rdy_out, if1.rdy_out, if0.rdy_out};
    for (int i = 0; i < 4; i++) begin
      got[0][i] = int'(if0.list_out[i]);
      got[1][i] = int'(if1.list_out[i]);
      got[2][i] = int'(if2.list_out[i]);
    end
  end

  // Reference: exact product, floor division by 2^sh, clamp to wp-bit signed range.
  function automatic int ref_p(int a, int b, int sh, int wp);
    longint p;
    longint lim;
    p   = longint'(a) * longint'(b);
    lim = longint'(1) << (wp - 1);
    p   = p >>> sh;
    if (p > lim - 1) p = lim - 1;
    if (p < -lim)    p = -lim;
    return int'(p);
  endfunction

  task automatic ref_vec(input int d, input vec_t a, input vec_t b, output vec_t e);
    for (int i = 0; i < 4; i++) e[i] = ref_p(a[i], b[i], cfg_sh[d], cfg_wp[d]);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic chk_vec(input string nm, input int d, input vec_t exp);
    for (int i = 0; i < 4; i++) chk($sformatf("%s[%0d]", nm, i), got[d][i], exp[i]);
  endtask

  task automatic drive(input vec_t a, input vec_t b);
    for (int i = 0; i < 4; i++) begin
      a_drv[i] = 8'(a[i]);
      b_drv[i] = 8'(b[i]);
    end
  endtask

  // Offer one vector to DUT d; return at the negedge vld_out is seen, lat = edges after accept.
  task automatic xact(input int d, input vec_t a, input vec_t b, output int lat);
    int t;
    @(negedge clk);
    drive(a, b);
    vld_d[d] = 1'b1;
    t = 0;
    while (!ro[d] && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) chk($sformatf("accept_timeout d%0d", d), 0, 1);
    @(posedge clk);
    @(negedge clk);
    vld_d[d] = 1'b0;
    lat = 0;
    while (!vo[d] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_rec_t tbl [8];
    vec_t     va, vb, vc, e, snap;
    vec_t     sa [3];
    vec_t     sb [3];
    int       lat, diff, n_sent, n_got;
    int       acc_cyc [$];
    int       out_cyc [$];

    tbl[0] = '{0, '{1, -2, 3, 127},     '{4, 5, -6, -128},     '{4, -10, -18, -16256}};
    tbl[1] = '{1, '{127, -128, -1, 5},  '{127, 127, 1, 3},     '{2047, -2048, -1, 3}};
    tbl[2] = '{2, '{1, -2, 3, 127},     '{4, 5, -6, -128},     '{4, -10, -18, -16256}};
    tbl[3] = '{0, '{127, -128, -1, 5},  '{127, 127, 1, 3},     '{16129, -16256, -1, 15}};
    tbl[4] = '{1, '{1, -2, 3, 127},     '{4, 5, -6, -128},     '{1, -3, -5, -2048}};
    tbl[5] = '{0, '{-128, -128, 127, 0}, '{-128, 127, -128, 5}, '{16384, -16256, -16256, 0}};
    tbl[6] = '{2, '{127, -128, -1, 5},  '{127, 127, 1, 3},     '{16129, -16256, -1, 15}};
    tbl[7] = '{1, '{-1, -3, 4, 64},     '{1, 1, 1, 64},        '{-1, -1, 1, 1024}};

    rst_n = 1'b0;
    vld_d = '0;
    rdy_d = 3'b111;
    for (int i = 0; i < 4; i++) begin
      a_drv[i] = '0;
      b_drv[i] = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #2;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_vld d%0d", d), vo[d], 0);
      chk($sformatf("rst_rdy d%0d", d), ro[d], 1);
      chk_vec($sformatf("rst_list d%0d", d), d, '{0, 0, 0, 0});
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed vectors
    for (int r = 0; r < 8; r++) begin
      xact(tbl[r].d, tbl[r].a, tbl[r].b, lat);
      chk($sformatf("tbl%0d lat", r), lat, cfg_ps[tbl[r].d]);
      chk_vec($sformatf("tbl%0d", r), tbl[r].d, tbl[r].e);
    end

    // Back-pressure on d0: result held for 10 cycles, waiting vector not accepted early
    va = '{10, -20, 30, -40};
    vb = '{3, 3, -3, -3};
    vc = '{-7, 8, 100, -100};
    rdy_d[0] = 1'b0;
    xact(0, va, vb, lat);
    chk("bp lat", lat, 2);
    ref_vec(0, va, vb, e);
    chk_vec("bp res", 0, e);
    for (int i = 0; i < 4; i++) snap[i] = e[i];
    drive(vc, vb);
    vld_d[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      chk("bp vld_out", vo[0], 1);
      chk("bp rdy_out", ro[0], 0);
      diff = 0;
      for (int i = 0; i < 4; i++) if (got[0][i] != snap[i]) diff++;
      chk("bp hold lanes_changed", diff, 0);
      @(negedge clk);
    end
    rdy_d[0] = 1'b1;
    #1;
    chk("bp rdy_out follows rdy_in", ro[0], 1);
    @(posedge clk);
    @(negedge clk);
    vld_d[0] = 1'b0;
    chk("bp transferred", vo[0], 0);
    lat = 0;
    while (!vo[0] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp lat2", lat, 2);
    ref_vec(0, vc, vb, e);
    chk_vec("bp res2", 0, e);

    // Streaming on d0: three vectors back to back
    for (int v = 0; v < 3; v++)
      for (int i = 0; i < 4; i++) begin
        sa[v][i] = int'($urandom_range(255)) - 128;
        sb[v][i] = int'($urandom_range(255)) - 128;
      end
    @(negedge clk);
    n_sent = 0;
    n_got  = 0;
    drive(sa[0], sb[0]);
    vld_d[0] = 1'b1;
    for (int cyc = 0; cyc < 40 && n_got < 3; cyc++) begin
      if (vo[0]) begin
        ref_vec(0, sa[n_got], sb[n_got], e);
        chk_vec($sformatf("stream%0d", n_got), 0, e);
        out_cyc.push_back(cyc);
        n_got++;
      end
      if (vld_d[0] && ro[0]) begin
        acc_cyc.push_back(cyc);
        n_sent++;
      end
      @(negedge clk);
      if (n_sent < 3) drive(sa[n_sent], sb[n_sent]);
      else vld_d[0] = 1'b0;
    end
    vld_d[0] = 1'b0;
    chk("stream outputs", n_got, 3);
    if (n_got == 3 && acc_cyc.size() == 3) begin
      chk("stream gap01", out_cyc[1] - out_cyc[0], 3);
      chk("stream gap12", out_cyc[2] - out_cyc[1], 3);
      chk("stream acc1 at out0", acc_cyc[1], out_cyc[0]);
      chk("stream acc2 at out1", acc_cyc[2], out_cyc[1]);
    end

    // Asynchronous reset one cycle into BUSY on d0
    @(negedge clk);
    va = '{5, 6, 7, 8};
    vb = '{9, 10, 11, 12};
    drive(va, vb);
    vld_d[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld_d[0] = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid vld_out", vo[0], 0);
    chk("rstmid rdy_out", ro[0], 1);
    chk_vec("rstmid list", 0, '{0, 0, 0, 0});
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rstmid no pulse", vo[0], 0);
    end
    xact(0, va, vb, lat);
    chk("rstmid lat", lat, 2);
    ref_vec(0, va, vb, e);
    chk_vec("rstmid res", 0, e);

    // Random vectors against the reference model on every configuration
    for (int n = 0; n < 20; n++) begin
      for (int d = 0; d < 3; d++) begin
        for (int i = 0; i < 4; i++) begin
          va[i] = int'($urandom_range(255)) - 128;
          vb[i] = int'($urandom_range(255)) - 128;
        end
        xact(d, va, vb, lat);
        chk($sformatf("rnd%0d d%0d lat", n, d), lat, cfg_ps[d]);
        ref_vec(d, va, vb, e);
        chk_vec($sformatf("rnd%0d d%0d", n, d), d, e);
      end
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
